// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the serial-to-parallel deserializer slice.
package sipo_pkg;

  localparam bit SIPO_MSB_FIRST = 1'b1;
  localparam bit SIPO_LSB_FIRST = 1'b0;

  // Bit-counter width for a given word width; never narrower than one bit.
  function automatic int unsigned CNT_W(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial input, parallel valid/ready output and status signals of sipo_deserializer.
interface sipo_deserializer_if #(
  parameter int unsigned WIDTH = 8
);
  import sipo_pkg::*;

  localparam int unsigned CW = CNT_W(WIDTH);

  logic             sin_valid;
  logic             sin_bit;
  logic             sin_sof;
  logic [WIDTH-1:0] p_data;
  logic             p_valid;
  logic             p_ready;
  logic [CW-1:0]    bit_cnt;
  logic             ovf_pulse;
  logic             ovf_sticky;
  logic             sof_err;
  logic             clr_err;

  modport master (
    output sin_valid, sin_bit, sin_sof, p_ready, clr_err,
    input  p_data, p_valid, bit_cnt, ovf_pulse, ovf_sticky, sof_err
  );

  modport slave (
    input  sin_valid, sin_bit, sin_sof, p_ready, clr_err,
    output p_data, p_valid, bit_cnt, ovf_pulse, ovf_sticky, sof_err
  );

endinterface

// File: rtl/sipo_hold_reg.sv
// One-entry valid/ready holding register; drops a word offered while full and not draining.
module sipo_hold_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_req,
  input  logic [WIDTH-1:0] load_data,
  input  logic             p_ready,
  input  logic             clr_err,
  output logic [WIDTH-1:0] p_data,
  output logic             p_valid,
  output logic             ovf_pulse,
  output logic             ovf_sticky
);

  logic accept;
  logic load_ok;
  logic drop;

  always_comb begin
    accept  = p_valid && p_ready;
    load_ok = load_req && (!p_valid || p_ready);
    drop    = load_req && p_valid && !p_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_data     <= '0;
      p_valid    <= 1'b0;
      ovf_pulse  <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      // Accept and load in the same cycle keeps p_valid high with the new word.
      if (load_ok) begin
        p_data  <= load_data;
        p_valid <= 1'b1;
      end else if (accept) begin
        p_valid <= 1'b0;
      end
      ovf_pulse <= drop;
      if (drop) begin
        ovf_sticky <= 1'b1;
      end else if (clr_err) begin
        ovf_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel converter: shift register, bit counter and start-of-frame resync
// feeding a one-word holding register.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = SIPO_MSB_FIRST
) (
  input  logic clk,
  input  logic rst_n,
  sipo_deserializer_if.slave bus
);

  localparam int unsigned   CW   = CNT_W(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [CW-1:0]    bit_cnt_q;
  logic [CW-1:0]    cnt_base;
  logic [CW-1:0]    cnt_nxt;
  logic             sof_hit;
  logic             complete;
  logic             sof_err_q;
  logic             sof_err_nxt;

  always_comb begin
    shreg_nxt   = shreg;
    cnt_nxt     = bit_cnt_q;
    sof_hit     = bus.sin_valid && bus.sin_sof;
    // A start-of-frame bit counts as bit 0 regardless of the partial word in flight.
    cnt_base    = sof_hit ? '0 : bit_cnt_q;
    complete    = bus.sin_valid && (cnt_base == LAST);
    sof_err_nxt = sof_hit && (bit_cnt_q != '0);
    if (bus.sin_valid) begin
      if (MSB_FIRST) begin
        shreg_nxt = {shreg[WIDTH-2:0], bus.sin_bit};
      end else begin
        shreg_nxt = {bus.sin_bit, shreg[WIDTH-1:1]};
      end
      cnt_nxt = complete ? '0 : cnt_base + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      bit_cnt_q <= '0;
      sof_err_q <= 1'b0;
    end else begin
      shreg     <= shreg_nxt;
      bit_cnt_q <= cnt_nxt;
      sof_err_q <= sof_err_nxt;
    end
  end

  assign bus.bit_cnt = bit_cnt_q;
  assign bus.sof_err = sof_err_q;

  sipo_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_req   (complete),
    .load_data  (shreg_nxt),
    .p_ready    (bus.p_ready),
    .clr_err    (bus.clr_err),
    .p_data     (bus.p_data),
    .p_valid    (bus.p_valid),
    .ovf_pulse  (bus.ovf_pulse),
    .ovf_sticky (bus.ovf_sticky)
  );

endmodule
